// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IM word address, pairs data with PC.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module fetch_unit #(
  parameter int unsigned N        = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h6800_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  output logic [N-1:0]  im_addr,
  input  logic [31:0]   im_data,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_inst,
  output logic          if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_req_valid;
  logic [31:0] w_target;
  logic        w_issue;

  assign w_target = branch_target & 32'hFFFF_FFFC;
  assign w_issue  = branch_taken | ~stall;

  // A stall re-requests the presented word so the synchronous IM keeps returning it.
  always_comb begin
    im_addr = r_pc[N+1:2];
    if (branch_taken) begin
      im_addr = w_target[N+1:2];
    end else if (stall) begin
      im_addr = r_req_pc[N+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
    end else if (branch_taken) begin
      r_req_pc    <= w_target;
      r_pc        <= w_target + 32'd4;
      r_req_valid <= 1'b1;
    end else if (!stall) begin
      r_req_pc    <= r_pc;
      r_pc        <= r_pc + 32'd4;
      r_req_valid <= 1'b1;
    end
  end

  assign if_pc    = r_req_pc;
  assign if_valid = r_req_valid;
  assign if_inst  = r_req_valid ? im_data : NOP_WORD;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_issue) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (stall && !branch_taken) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corner sequences, randomized run vs. PC-stream model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [6:0]  im_addr;
  logic [31:0] im_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_vec;
  int n_bad;

  // Reference model: next PC to request, PC presented, valid, and event counts.
  logic [31:0] m_next;
  logic [31:0] m_pres;
  logic        m_valid;
  int unsigned m_fetch;
  int unsigned m_stall;
  logic [6:0]  seen_addr;

  fetch_unit #(.N(7), .RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .im_addr(im_addr),
    .im_data(im_data),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read IM with IM[k] = 0x1000_0000 | k
  always @(posedge clk) im_data <= 32'h1000_0000 | {25'd0, im_addr};

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h1000_0000 | ((pc >> 2) & 32'h7F);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next  = 32'h0;
    m_pres  = 32'h0;
    m_valid = 1'b0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // Drive on the falling edge, capture the issued address, then let one rising edge pass.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    stall = s;
    branch_taken = b;
    branch_target = t;
    #1;
    seen_addr = im_addr;
    @(posedge clk);
    #1;
    if (b) begin
      m_pres  = {t[31:2], 2'b00};
      m_next  = m_pres + 32'd4;
      m_valid = 1'b1;
      m_fetch++;
    end else if (s) begin
      m_stall++;
    end else begin
      m_pres  = m_next;
      m_next  = m_next + 32'd4;
      m_valid = 1'b1;
      m_fetch++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    chk({tag, "_pc"}, if_pc, m_pres);
    chk({tag, "_inst"}, if_inst, m_valid ? word_of(m_pres) : NOP);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fcnt"}, fetch_count, m_fetch);
    chk({tag, "_scnt"}, stall_count, m_stall);
`endif
  endtask

  // Assert reset mid-cycle (asynchronously), check immediately, release a cycle later.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    branch_taken = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_rst_pc"}, if_pc, 32'h0);
    chk({tag, "_rst_inst"}, if_inst, NOP);
    chk({tag, "_rst_addr"}, {25'd0, im_addr}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_rst_fcnt"}, fetch_count, 32'd0);
    chk({tag, "_rst_scnt"}, stall_count, 32'd0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk({tag, "_cyc1_valid"}, {31'd0, if_valid}, 32'd0);
  endtask

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    rst_n = 1'b1;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         32'h8};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         32'h8};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         32'hC};
    tbl[7]  = '{1'b0, 1'b1, 32'h43,        32'h40};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         32'h44};
    tbl[9]  = '{1'b1, 1'b1, 32'h20,        32'h20};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         32'h24};
    tbl[11] = '{1'b0, 1'b1, 32'h1F8,       32'h1F8};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         32'h1FC};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         32'h200};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         32'h204};
    tbl[15] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tbl[16] = '{1'b0, 1'b0, 32'h0,         32'h0};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", {31'd0, if_valid}, 32'd0);
    chk("init_pc", if_pc, 32'h0);
    chk("init_inst", if_inst, NOP);
    chk("init_addr", {25'd0, im_addr}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("cyc1_valid", {31'd0, if_valid}, 32'd0);
    chk("cyc1_inst", if_inst, NOP);

    // Directed table: the address issued in a cycle is the word presented after its edge.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s, tbl[i].b, tbl[i].t);
      chk($sformatf("tbl%0d_addr", i), {25'd0, seen_addr}, (tbl[i].exp_pc >> 2) & 32'h7F);
      chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, 32'd1);
      chk($sformatf("tbl%0d_inst", i), if_inst, word_of(tbl[i].exp_pc));
    end

    // Reset asserted in the middle of a stall, then a stall on the first cycle after release.
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("midstall_pc", if_pc, 32'h0);
    do_reset("midstall");
    step(1'b1, 1'b0, 32'h0);
    chk("poststall_valid", {31'd0, if_valid}, 32'd0);
    chk("poststall_pc", if_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_inst", if_inst, 32'h1000_0000);
    step(1'b0, 1'b0, 32'h0);
    chk("second_pc", if_pc, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    do_reset("perf");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    chk("perf_fetch10", fetch_count, 32'd10);
    chk("perf_stall3", stall_count, 32'd3);
    step(1'b1, 1'b1, 32'h80);
    chk("perf_brstall_fetch", fetch_count, 32'd11);
    chk("perf_brstall_stall", stall_count, 32'd3);
`endif

    // Randomized run against the model, with occasional mid-run resets.
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      logic        rs;
      logic        rb;
      logic [31:0] rt;
      rs = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 3) == 0) ? $urandom : {23'd0, $urandom_range(0, 511)};
      if (i % 150 == 149) do_reset($sformatf("rrst%0d", i));
      step(rs, rb, rt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
